// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and frame sequencer in front of a shared uart_transmitter.
// One whole frame per grant, then an optional gap; a stuck frame is aborted by timeout.
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ID_W      = 2,
    parameter int GAP_TICKS = 16,
    parameter int TIMEOUT   = 512,
    parameter int CNT_W     = 10
) (
    input  logic               s_tick,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic               tx_start,
    output logic [7:0]         din,
    input  logic               tx_done_tick,
    output logic               busy,
    output logic [ID_W-1:0]    active_id,
    output logic               timeout_err
);
    typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

    localparam state_t           POST     = (GAP_TICKS > 0) ? GAP : IDLE;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    state_t                state, state_nx;
    logic [ID_W-1:0]       ptr, ptr_nx;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic [N_REQ-1:0]      gnt_nx;
    logic                  tx_start_nx, err_nx;
    logic [7:0]            din_nx;
    logic [ID_W-1:0]       id_nx;
    logic [N_REQ-1:0][7:0] req_byte;
    logic                  found;
    logic [ID_W-1:0]       winner;

    assign req_byte = req_data;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        // First pass scans ptr..N_REQ-1; if empty, the lowest set bit is the wrapped winner.
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req[j] && (ID_W'(j) >= ptr)) begin
                found  = 1'b1;
                winner = ID_W'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req[j]) begin
                found  = 1'b1;
                winner = ID_W'(j);
            end
        end
    end

    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        cnt_nx      = cnt;
        gnt_nx      = '0;
        tx_start_nx = 1'b0;
        err_nx      = 1'b0;
        din_nx      = din;
        id_nx       = active_id;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nx   = N_REQ'(1) << winner;
                    din_nx   = req_byte[winner];
                    id_nx    = winner;
                    ptr_nx   = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                tx_start_nx = 1'b1;
                cnt_nx      = '0;
                state_nx    = BUSY;
            end
            BUSY: begin
                // Done wins over a timeout expiring in the same cycle.
                if (tx_done_tick) begin
                    cnt_nx   = '0;
                    state_nx = POST;
                end else if (cnt == TO_LAST) begin
                    err_nx   = 1'b1;
                    cnt_nx   = '0;
                    state_nx = POST;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) state_nx = IDLE;
                else                 cnt_nx   = cnt + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge s_tick) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            gnt         <= '0;
            tx_start    <= 1'b0;
            din         <= '0;
            busy        <= 1'b0;
            active_id   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            cnt         <= cnt_nx;
            gnt         <= gnt_nx;
            tx_start    <= tx_start_nx;
            din         <= din_nx;
            busy        <= (state_nx != IDLE);
            active_id   <= id_nx;
            timeout_err <= err_nx;
        end
    end
endmodule
